masked_subbytes_seq: RTL and testbench

- Sequencer that sits directly upstream and downstream of the pipelined two-share masked AES S-box lanes.
- Accepts a full 128-bit two-share AES state and streams it byte-wise into NUM_SBOX parallel S-box lanes.
- Distributes per-lane fresh randomness, realigns the lane outputs using a valid/index delay line, and returns the complete SubBytes result in both shares with a done pulse.

---
 rtl/masked_subbytes_seq.sv | 158 +++++++++++++++
 tb/tb_masked_subbytes_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_subbytes_seq.sv
// Byte-group sequencer around NUM_SBOX two-share masked AES S-box lanes.
// Feeds the latched state, realigns lane outputs and collects the result.
module masked_subbytes_seq #(
  parameter int NUM_SBOX = 4,
  parameter int SBOX_LAT = 3,
  parameter int RAND_W   = 28
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  input  logic [127:0]               state_in0,
  input  logic [127:0]               state_in1,
  output logic                       busy,
  output logic                       done,
  output logic [127:0]               state_out0,
  output logic [127:0]               state_out1,
  output logic [8*NUM_SBOX-1:0]      sbox_in0,
  output logic [8*NUM_SBOX-1:0]      sbox_in1,
  output logic [RAND_W*NUM_SBOX-1:0] sbox_r,
  input  logic [8*NUM_SBOX-1:0]      sbox_out0,
  input  logic [8*NUM_SBOX-1:0]      sbox_out1,
  input  logic [RAND_W*NUM_SBOX-1:0] rand_in,
  output logic                       rand_req
);
  localparam int NFEED = 16 / NUM_SBOX;
  localparam int CW    = (NFEED > 1) ? $clog2(NFEED) : 1;
  localparam int GW    = 8 * NUM_SBOX;
  localparam logic [CW-1:0] K_LAST = CW'(NFEED - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  // Packed views: element g holds byte group g (bytes g*NUM_SBOX .. g*NUM_SBOX+NUM_SBOX-1).
  logic [NFEED-1:0][GW-1:0] in0_q, in0_d, in1_q, in1_d;
  logic [NFEED-1:0][GW-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [SBOX_LAT-1:0] dlv_q, dlv_d;
  logic [SBOX_LAT-1:0][CW-1:0] dli_q, dli_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic push_v;
  logic [CW-1:0] push_idx;
  logic head_v;
  logic [CW-1:0] head_idx;

  assign head_v   = dlv_q[SBOX_LAT-1];
  assign head_idx = dli_q[SBOX_LAT-1];

  // Next-state, lane feed, delay-line shift and result capture
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    done_d   = 1'b0;
    sbox_in0 = '0;
    sbox_in1 = '0;
    push_v   = 1'b0;
    push_idx = '0;
    dlv_d    = dlv_q;
    dli_d    = dli_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in0_d   = state_in0;
          in1_d   = state_in1;
          k_d     = '0;
          state_d = S_FEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        sbox_in0 = in0_q[k_q];
        sbox_in1 = in1_q[k_q];
        push_v   = 1'b1;
        push_idx = k_q;
        k_d      = k_q + CW'(1);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FEED;
        end
      end
      S_DRAIN: begin
        if (head_v && (head_idx == K_LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lane outputs can already be returning while later groups are still being fed.
    if (head_v) begin
      res0_d[head_idx] = sbox_out0;
      res1_d[head_idx] = sbox_out1;
    end else begin
      res0_d = res0_q;
      res1_d = res1_q;
    end

    for (int i = SBOX_LAT - 1; i > 0; i--) begin
      dlv_d[i] = dlv_q[i-1];
      dli_d[i] = dli_q[i-1];
    end
    dlv_d[0] = push_v;
    dli_d[0] = push_idx;

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and delay-line registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      dlv_q   <= '0;
      dli_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      dlv_q   <= dlv_d;
      dli_q   <= dli_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign rand_req   = busy_q;
  assign done       = done_q;
  assign state_out0 = res0_q;
  assign state_out1 = res1_q;
  assign sbox_r     = busy_q ? rand_in : '0;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Scoreboard bench for masked_subbytes_seq with NUM_SBOX = 4, 1 and 16 side by side,
// each driving a behavioural masked S-box pipeline built from GF(2^8) arithmetic.
module tb_masked_subbytes_seq;
  localparam int SBOX_LAT = 3;
  localparam int RAND_W   = 28;
  localparam int NCFG     = 3;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [127:0] state_in0;
  logic [127:0] state_in1;

  logic         done_w  [NCFG];
  logic         busy_w  [NCFG];
  logic         rreq_w  [NCFG];
  logic         rzero_w [NCFG];
  logic         szero_w [NCFG];
  logic [127:0] so0_w   [NCFG];
  logic [127:0] so1_w   [NCFG];

  int total = 0;
  int bad   = 0;
  int lat_tab [NCFG];
  int free_at [NCFG];
  logic [127:0] exp_q [NCFG][$];
  int           exp_t [NCFG][$];
  logic [7:0]   sbox_tab [256];

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[x[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  for (genvar G = 0; G < NCFG; G++) begin : g_cfg
    localparam int NS = (G == 0) ? 4 : ((G == 1) ? 1 : 16);
    logic [8*NS-1:0]      sbin0, sbin1, sbout0, sbout1;
    logic [RAND_W*NS-1:0] sbr, rnd;
    logic [8*NS-1:0]      p0 [SBOX_LAT];
    logic [8*NS-1:0]      p1 [SBOX_LAT];
    logic [31:0]          rtmp;
    logic                 dn, bz, rq;
    logic [127:0]         o0, o1;

    masked_subbytes_seq #(.NUM_SBOX(NS), .SBOX_LAT(SBOX_LAT), .RAND_W(RAND_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start),
      .state_in0(state_in0), .state_in1(state_in1),
      .busy(bz), .done(dn), .state_out0(o0), .state_out1(o1),
      .sbox_in0(sbin0), .sbox_in1(sbin1), .sbox_r(sbr),
      .sbox_out0(sbout0), .sbox_out1(sbout1),
      .rand_in(rnd), .rand_req(rq)
    );

    // fresh PRNG word every cycle
    always @(negedge CLK) begin
      for (int w = 0; w < NS; w++) begin
        rtmp = $urandom;
        rnd[RAND_W*w +: RAND_W] = rtmp[RAND_W-1:0];
      end
    end

    // masked lane model: share0 = S(x0^x1)^m, share1 = m, m taken from lane randomness
    always @(posedge CLK) begin
      for (int j = 0; j < NS; j++) begin
        p0[0][8*j +: 8] <= sbox_tab[sbin0[8*j +: 8] ^ sbin1[8*j +: 8]] ^ sbr[RAND_W*j +: 8];
        p1[0][8*j +: 8] <= sbr[RAND_W*j +: 8];
      end
      for (int s = 1; s < SBOX_LAT; s++) begin
        p0[s] <= p0[s-1];
        p1[s] <= p1[s-1];
      end
    end

    assign sbout0     = p0[SBOX_LAT-1];
    assign sbout1     = p1[SBOX_LAT-1];
    assign done_w[G]  = dn;
    assign busy_w[G]  = bz;
    assign rreq_w[G]  = rq;
    assign so0_w[G]   = o0;
    assign so1_w[G]   = o1;
    assign rzero_w[G] = (sbr == '0);
    assign szero_w[G] = (sbin0 == '0) && (sbin1 == '0);
  end

  // monitor: every done pops the scoreboard of its instance
  always @(negedge CLK) begin
    int now;
    now = int'(($time - 10) / 10);
    for (int i = 0; i < NCFG; i++) begin
      if (RST_N && done_w[i]) begin
        check($sformatf("done_expected[%0d]", i), {127'd0, exp_q[i].size() > 0}, 128'd1);
        if (exp_q[i].size() > 0) begin
          check($sformatf("result[%0d]", i), so0_w[i] ^ so1_w[i], exp_q[i].pop_front());
          check($sformatf("done_cycle[%0d]", i), 128'(now), 128'(exp_t[i].pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [127:0] x0, input logic [127:0] x1);
    int a;
    @(negedge CLK);
    state_in0 = x0;
    state_in1 = x1;
    start     = 1'b1;
    a = int'($time / 10);
    for (int i = 0; i < NCFG; i++) begin
      if (a >= free_at[i]) begin
        exp_q[i].push_back(subbytes(x0 ^ x1));
        exp_t[i].push_back(a + lat_tab[i]);
        free_at[i] = a + lat_tab[i] + 1;
      end
    end
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic pend;
    pend = 1'b1;
    for (int c = 0; c < budget && pend; c++) begin
      @(negedge CLK);
      pend = 1'b0;
      for (int i = 0; i < NCFG; i++) begin
        if (busy_w[i] || exp_q[i].size() != 0) pend = 1'b1;
      end
    end
    check("wait_idle", {127'd0, pend}, 128'd0);
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("%s_busy[%0d]", tag, i), {127'd0, busy_w[i]}, 128'd0);
      check($sformatf("%s_done[%0d]", tag, i), {127'd0, done_w[i]}, 128'd0);
      check($sformatf("%s_rreq[%0d]", tag, i), {127'd0, rreq_w[i]}, 128'd0);
      check($sformatf("%s_out0[%0d]", tag, i), so0_w[i], 128'd0);
      check($sformatf("%s_out1[%0d]", tag, i), so1_w[i], 128'd0);
      check($sformatf("%s_rzero[%0d]", tag, i), {127'd0, rzero_w[i]}, 128'd1);
      check($sformatf("%s_szero[%0d]", tag, i), {127'd0, szero_w[i]}, 128'd1);
    end
  endtask

  initial begin
    logic [7:0]   inv;
    logic [127:0] x, m, r;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(v[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      sbox_tab[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    lat_tab[0] = 16 / 4 + SBOX_LAT;
    lat_tab[1] = 16 / 1 + SBOX_LAT;
    lat_tab[2] = 16 / 16 + SBOX_LAT;
    for (int i = 0; i < NCFG; i++) free_at[i] = 0;

    RST_N     = 1'b0;
    start     = 1'b0;
    state_in0 = 128'd0;
    state_in1 = 128'd0;
    repeat (3) @(negedge CLK);
    check_quiet("reset");
    RST_N = 1'b1;

    // directed share split, second share zero
    issue(128'h00112233445566778899aabbccddeeff, 128'd0);
    wait_idle(40);
    r = so0_w[0] ^ so1_w[0];
    check("byte_ff", {120'd0, r[7:0]}, 128'h16);
    check("byte_00", {120'd0, r[127:120]}, 128'h63);
    check("idle_rzero", {127'd0, rzero_w[0]}, 128'd1);

    // start while busy is ignored
    issue({4{$urandom}}, {4{$urandom}});
    issue({4{$urandom}}, {4{$urandom}});
    wait_idle(40);

    // back-to-back start in the done cycle of the default configuration
    issue({4{$urandom}}, {4{$urandom}});
    repeat (6) @(negedge CLK);
    issue({4{$urandom}}, {4{$urandom}});
    wait_idle(40);

    // random masked inputs with random spacing
    for (int n = 0; n < 20; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      issue(x ^ m, m);
      repeat ($urandom_range(0, 24)) @(negedge CLK);
    end
    wait_idle(60);

    // reset in the middle of an operation
    issue({4{$urandom}}, {4{$urandom}});
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      exp_q[i].delete();
      exp_t[i].delete();
      free_at[i] = 0;
    end
    @(negedge CLK);
    check_quiet("midreset");
    RST_N = 1'b1;
    x = {$urandom, $urandom, $urandom, $urandom};
    m = {$urandom, $urandom, $urandom, $urandom};
    issue(x ^ m, m);
    wait_idle(40);

    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("leftover[%0d]", i), 128'(exp_q[i].size()), 128'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
